// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed byte stream (SYNC, LEN0, LEN1, data
// bytes, optional XOR checksum). It assembles little-endian 32-bit words,
// writes them to IMEM at byte addresses 0, 4, 8, ..., and holds the core in
// reset until a valid image has been loaded.
// The trailing checksum byte is included only when IMEM_BOOT_CHECKSUM_EN is
// defined.
module imem_boot_loader #(
  parameter int         addr_width_IMEM = 8,
  parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
  input  logic                       clk,
  input  logic                       async_reset_n,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  input  logic                       start,
  output logic                       imem_we,
  output logic [addr_width_IMEM-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       core_hold,
  output logic                       load_done,
  output logic                       load_err
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << (addr_width_IMEM - 2);

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
`ifdef IMEM_BOOT_CHECKSUM_EN
    S_CSUM = 3'd4,
`endif
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  // State that follows the last data word (or an empty image).
`ifdef IMEM_BOOT_CHECKSUM_EN
  localparam state_t S_AFTER = S_CSUM;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [15:0]                r_len;
  logic [15:0]                r_word_idx;
  logic [1:0]                 r_byte_cnt;
  logic [23:0]                r_shift;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]                 r_csum;
`endif
  logic                       r_we;
  logic [addr_width_IMEM-1:0] r_addr;
  logic [31:0]                r_wdata;
  logic                       r_hold;
  logic                       r_done;
  logic                       r_err;

  logic                       w_acc;
  logic [15:0]                w_len_n;
  logic                       w_len_big;
  logic                       w_last_word;
  logic [addr_width_IMEM-1:0] w_addr;

  assign rx_ready    = (r_state != S_DONE) && (r_state != S_ERR);
  assign w_acc       = rx_valid & rx_ready;
  assign w_len_n     = {rx_data, r_len[7:0]};
  assign w_len_big   = {1'b0, w_len_n} > MAX_WORDS;
  assign w_last_word = (r_word_idx == (r_len - 16'd1));
  assign w_addr      = addr_width_IMEM'({r_word_idx, 2'b00});

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_hold  = r_hold;
  assign load_done  = r_done;
  assign load_err   = r_err;

  // State register.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) r_state <= S_SYNC;
    else                r_state <= w_state_nxt;
  end

  // Next-state decode: frame parsing and start re-arm.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SYNC: if (w_acc && (rx_data == SYNC_BYTE)) w_state_nxt = S_LEN0;
      S_LEN0: if (w_acc) w_state_nxt = S_LEN1;
      S_LEN1: begin
        if (w_acc) begin
          if (w_len_big)              w_state_nxt = S_ERR;
          else if (w_len_n == 16'd0)  w_state_nxt = S_AFTER;
          else                        w_state_nxt = S_DATA;
        end
      end
      S_DATA: if (w_acc && (r_byte_cnt == 2'd3) && w_last_word) w_state_nxt = S_AFTER;
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CSUM: if (w_acc) w_state_nxt = (rx_data == r_csum) ? S_DONE : S_ERR;
`endif
      S_DONE: if (start) w_state_nxt = S_SYNC;
      S_ERR:  if (start) w_state_nxt = S_SYNC;
      default: w_state_nxt = S_SYNC;
    endcase
  end

  // Datapath: length capture, byte assembly, IMEM write strobe and status flags.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      r_csum     <= '0;
`endif
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_hold     <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_LEN0: if (w_acc) r_len[7:0] <= rx_data;
        S_LEN1: begin
          if (w_acc) begin
            r_len[15:8] <= rx_data;
            r_word_idx  <= '0;
            r_byte_cnt  <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            r_csum      <= '0;
`endif
          end
        end
        S_DATA: begin
          if (w_acc) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            r_csum     <= r_csum ^ rx_data;
`endif
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_shift[7:0]   <= rx_data;
              2'd1: r_shift[15:8]  <= rx_data;
              2'd2: r_shift[23:16] <= rx_data;
              default: begin
                // Fourth byte completes the word; the write overlaps the next byte.
                r_we       <= 1'b1;
                r_wdata    <= {rx_data, r_shift};
                r_addr     <= w_addr;
                r_word_idx <= r_word_idx + 16'd1;
              end
            endcase
          end
        end
        default: ;
      endcase

      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
        r_done <= 1'b1;
        r_hold <= 1'b0;
      end
      if ((w_state_nxt == S_ERR) && (r_state != S_ERR)) begin
        r_err  <= 1'b1;
        r_hold <= 1'b1;
        r_done <= 1'b0;
      end
      if (((r_state == S_DONE) || (r_state == S_ERR)) && start) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
        r_addr <= '0;
        r_hold <= 1'b1;
      end
    end
  end

endmodule
